bch_dec_ctrl: RTL and testbench

BCH_DEC_CTRL -- requirements
Module: bch_dec_ctrl

---
 rtl/bch_dec_ctrl_if.sv | 33 +++
 rtl/bch_dec_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_bch_dec_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_dec_ctrl_if.sv
// Handshake and locator bus for the BCH(15,7) decoder controller.
// slave = controller side, master = upstream/downstream/locator side.
interface bch_dec_ctrl_if;
    localparam int unsigned N  = 15;
    localparam int unsigned GW = 4;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [GW-1:0] syn_s1;
    logic [GW-1:0] syn_s2;
    logic [GW-1:0] syn_s3;
    logic [GW-1:0] loc_lambda1;
    logic [GW-1:0] loc_lambda2;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [1:0]    out_err_cnt;
    logic          out_fail;
    logic          busy;

    modport slave (
        input  in_valid, in_data, loc_lambda1, loc_lambda2, out_ready,
        output in_ready, syn_s1, syn_s2, syn_s3, out_valid, out_data,
        out_err_cnt, out_fail, busy
    );

    modport master (
        output in_valid, in_data, loc_lambda1, loc_lambda2, out_ready,
        input  in_ready, syn_s1, syn_s2, syn_s3, out_valid, out_data,
        out_err_cnt, out_fail, busy
    );
endinterface

// File: rtl/bch_dec_ctrl.sv
// BCH(15,7) decoder controller: syndromes, external locator handoff, Chien search.
// Optional macro BCH_ZERO_SKIP_EN: zero syndromes skip LOC/CHIEN and go straight to DONE.
module bch_dec_ctrl #(
    parameter int unsigned LOC_LAT = 2
) (
    input logic           clk,
    input logic           rst_n,
    bch_dec_ctrl_if.slave bus
);
    localparam int unsigned N      = 15;
    localparam int unsigned GW     = 4;
    localparam int unsigned CW     = 4;
    localparam logic [CW-1:0] LAST_POS = CW'(N - 1);
    localparam logic [CW-1:0] LAST_LOC = CW'(LOC_LAT - 1);
    localparam logic [GW-1:0] ALPHA    = 4'd2;
    localparam logic [GW-1:0] ALPHA3   = 4'd8;
    localparam logic [GW-1:0] ALPHA13  = 4'd13;
    localparam logic [GW-1:0] ALPHA14  = 4'd9;
`ifdef BCH_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SYN, LOC, CHIEN, DONE} state_e;

    // GF(2^4) multiply, reduction by x^4 + x + 1
    function automatic logic [GW-1:0] gf_mul(input logic [GW-1:0] a, input logic [GW-1:0] b);
        logic [GW-1:0] p;
        logic [GW-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic [N-1:0]  work_q, work_d;
    logic [GW-1:0] s1_q, s1_d, s3_q, s3_d;
    logic [GW-1:0] t1_q, t1_d, t2_q, t2_d;
    logic [1:0]    deg_q, deg_d;
    logic [1:0]    roots_q, roots_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [1:0]    out_err_q, out_err_d;
    logic          out_fail_q, out_fail_d;

    logic [CW-1:0] syn_idx;
    logic          r_bit;
    logic          root;
    logic          syn_nz;

    assign syn_idx = CW'(LAST_POS - cnt_q);
    assign r_bit   = data_q[syn_idx];
    assign root    = ((4'd1 ^ t1_q ^ t2_q) == 4'd0);
    assign syn_nz  = (s1_q != 4'd0) || (s3_q != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            work_q      <= '0;
            s1_q        <= '0;
            s3_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            deg_q       <= '0;
            roots_q     <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            out_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            work_q      <= work_d;
            s1_q        <= s1_d;
            s3_q        <= s3_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            deg_q       <= deg_d;
            roots_q     <= roots_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_fail_q  <= out_fail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        work_d      = work_q;
        s1_d        = s1_q;
        s3_d        = s3_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        deg_d       = deg_q;
        roots_d     = roots_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_fail_d  = out_fail_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d = SYN;
                    cnt_d   = '0;
                    data_d  = bus.in_data;
                    work_d  = bus.in_data;
                    s1_d    = '0;
                    s3_d    = '0;
                end
            end
            // Horner evaluation, highest-order coefficient first
            SYN: begin
                s1_d  = gf_mul(s1_q, ALPHA) ^ {3'b000, r_bit};
                s3_d  = gf_mul(s3_q, ALPHA3) ^ {3'b000, r_bit};
                cnt_d = CW'(cnt_q + 4'd1);
                if (cnt_q == LAST_POS) begin
                    cnt_d = '0;
                    if (ZERO_SKIP && (s1_d == 4'd0) && (s3_d == 4'd0)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = data_q;
                        out_err_d   = 2'd0;
                        out_fail_d  = 1'b0;
                    end else begin
                        state_d = LOC;
                    end
                end
            end
            LOC: begin
                cnt_d = CW'(cnt_q + 4'd1);
                if (cnt_q == LAST_LOC) begin
                    cnt_d   = '0;
                    t1_d    = bus.loc_lambda1;
                    t2_d    = bus.loc_lambda2;
                    roots_d = 2'd0;
                    if (bus.loc_lambda2 != 4'd0)      deg_d = 2'd2;
                    else if (bus.loc_lambda1 != 4'd0) deg_d = 2'd1;
                    else                              deg_d = 2'd0;
                    state_d = CHIEN;
                end
            end
            // Position i tests x = alpha^-i; final step folds in position 14
            CHIEN: begin
                t1_d = gf_mul(t1_q, ALPHA14);
                t2_d = gf_mul(t2_q, ALPHA13);
                if (root) begin
                    work_d = work_q ^ (15'd1 << cnt_q);
                    if (roots_q != 2'd3) roots_d = 2'(roots_q + 2'd1);
                end
                cnt_d = CW'(cnt_q + 4'd1);
                if (cnt_q == LAST_POS) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    if (syn_nz && ((deg_q == 2'd0) || (roots_d != deg_q))) begin
                        out_fail_d = 1'b1;
                        out_data_d = data_q;
                        out_err_d  = 2'd0;
                    end else begin
                        out_fail_d = 1'b0;
                        out_data_d = work_d;
                        out_err_d  = roots_d;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.syn_s1      = s1_q;
    assign bus.syn_s2      = gf_mul(s1_q, s1_q);
    assign bus.syn_s3      = s3_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_err_cnt = out_err_q;
    assign bus.out_fail    = out_fail_q;
endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Directed bench for bch_dec_ctrl with a table-driven ideal PGZ locator model.
module tb_bch_dec_ctrl;
    localparam int unsigned LOC_LAT = 2;
    localparam int FULL_LAT = 31 + LOC_LAT;
`ifdef BCH_ZERO_SKIP_EN
    localparam int ZERO_LAT = 16;
`else
    localparam int ZERO_LAT = FULL_LAT;
`endif

    logic clk;
    logic rst_n;
    logic force_zero;
    logic [3:0] m_l1, m_l2;
    int checks;
    int errors;

    bch_dec_ctrl_if bus ();

    bch_dec_ctrl #(.LOC_LAT(LOC_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gf_exp(input int k);
        case (k % 15)
            0: return 4'd1;   1: return 4'd2;   2: return 4'd4;   3: return 4'd8;
            4: return 4'd3;   5: return 4'd6;   6: return 4'd12;  7: return 4'd11;
            8: return 4'd5;   9: return 4'd10;  10: return 4'd7;  11: return 4'd14;
            12: return 4'd15; 13: return 4'd13; 14: return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    function automatic int gf_log(input logic [3:0] a);
        for (int k = 0; k < 15; k++) if (gf_exp(k) == a) return k;
        return 0;
    endfunction

    function automatic logic [3:0] tmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0 || b == 4'd0) return 4'd0;
        return gf_exp(gf_log(a) + gf_log(b));
    endfunction

    function automatic logic [3:0] tinv(input logic [3:0] a);
        return gf_exp(15 - gf_log(a));
    endfunction

    // Ideal PGZ: lambda1 = S1, lambda2 = (S3 + S1^3) / S1
    always_comb begin
        m_l1 = 4'd0;
        m_l2 = 4'd0;
        if (bus.syn_s1 != 4'd0) begin
            m_l1 = bus.syn_s1;
            m_l2 = tmul(bus.syn_s3 ^ tmul(tmul(bus.syn_s1, bus.syn_s1), bus.syn_s1),
                        tinv(bus.syn_s1));
        end
    end
    assign bus.loc_lambda1 = force_zero ? 4'd0 : m_l1;
    assign bus.loc_lambda2 = force_zero ? 4'd0 : m_l2;

    task automatic run_word(input logic [14:0] d, output logic [14:0] od, output logic [1:0] oe,
                            output logic of, output int lat);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 20 && bus.in_ready !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (lat < 100 && bus.out_valid !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        od = bus.out_data;
        oe = bus.out_err_cnt;
        of = bus.out_fail;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b vld=%b want 0 0 0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 15'h0 || bus.out_err_cnt !== 2'd0 || bus.out_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got data=%h err=%0d fail=%b want 0 0 0",
                     bus.out_data, bus.out_err_cnt, bus.out_fail);
        end
        checks++;
        if (bus.syn_s1 !== 4'd0 || bus.syn_s2 !== 4'd0 || bus.syn_s3 !== 4'd0) begin
            errors++;
            $display("FAIL reset_syn got %0d %0d %0d want 0 0 0",
                     bus.syn_s1, bus.syn_s2, bus.syn_s3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_zero_word;
        logic [14:0] od; logic [1:0] oe; logic of; int lat;
        run_word(15'h0000, od, oe, of, lat);
        checks++;
        if (od !== 15'h0 || oe !== 2'd0 || of !== 1'b0) begin
            errors++;
            $display("FAIL zero_word got data=%h err=%0d fail=%b want 0000 0 0", od, oe, of);
        end
        checks++;
        if (lat != ZERO_LAT) begin
            errors++;
            $display("FAIL zero_latency got %0d want %0d", lat, ZERO_LAT);
        end
    endtask

    task automatic test_single_error;
        logic [14:0] od; logic [1:0] oe; logic of; int lat;
        run_word(15'h0010, od, oe, of, lat);
        checks++;
        if (bus.syn_s1 !== 4'd3 || bus.syn_s2 !== 4'd5 || bus.syn_s3 !== 4'd15) begin
            errors++;
            $display("FAIL single_syn got %0d %0d %0d want 3 5 15",
                     bus.syn_s1, bus.syn_s2, bus.syn_s3);
        end
        checks++;
        if (od !== 15'h0 || oe !== 2'd1 || of !== 1'b0) begin
            errors++;
            $display("FAIL single_fix got data=%h err=%0d fail=%b want 0000 1 0", od, oe, of);
        end
        checks++;
        if (lat != FULL_LAT) begin
            errors++;
            $display("FAIL single_latency got %0d want %0d", lat, FULL_LAT);
        end
    endtask

    task automatic test_double_error;
        logic [14:0] od; logic [1:0] oe; logic of; int lat;
        run_word(15'h4001, od, oe, of, lat);
        checks++;
        if (bus.syn_s1 !== 4'd8 || bus.syn_s3 !== 4'd14) begin
            errors++;
            $display("FAIL double_syn got s1=%0d s3=%0d want 8 14", bus.syn_s1, bus.syn_s3);
        end
        checks++;
        if (od !== 15'h0 || oe !== 2'd2 || of !== 1'b0) begin
            errors++;
            $display("FAIL double_fix got data=%h err=%0d fail=%b want 0000 2 0", od, oe, of);
        end
    endtask

    task automatic test_uncorrectable;
        logic [14:0] od; logic [1:0] oe; logic of; int lat;
        force_zero = 1'b1;
        run_word(15'h0010, od, oe, of, lat);
        force_zero = 1'b0;
        checks++;
        if (od !== 15'h0010 || oe !== 2'd0 || of !== 1'b1) begin
            errors++;
            $display("FAIL uncorrectable got data=%h err=%0d fail=%b want 0010 0 1", od, oe, of);
        end
    endtask

    task automatic test_backpressure;
        logic [14:0] od; logic [1:0] oe; logic of; int lat;
        bus.out_ready = 1'b0;
        run_word(15'h4001, od, oe, of, lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 15'h0 || bus.out_err_cnt !== 2'd2 ||
                bus.out_fail !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d got vld=%b data=%h err=%0d fail=%b rdy=%b busy=%b want 1 0000 2 0 0 1",
                         k, bus.out_valid, bus.out_data, bus.out_err_cnt, bus.out_fail,
                         bus.in_ready, bus.busy);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL release got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_in_chien;
        logic [14:0] od; logic [1:0] oe; logic of; int lat;
        bus.in_valid = 1'b1;
        bus.in_data  = 15'h4001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Cycle 1 is right after acceptance; CHIEN cycle 5 is cycle 20 + LOC_LAT
        for (int k = 1; k < 20 + int'(LOC_LAT); k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL chien_busy got busy=%b vld=%b want 1 0", bus.busy, bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 15'h0 || bus.out_err_cnt !== 2'd0 || bus.out_fail !== 1'b0 ||
            bus.syn_s1 !== 4'd0 || bus.syn_s2 !== 4'd0 || bus.syn_s3 !== 4'd0) begin
            errors++;
            $display("FAIL midreset got rdy=%b busy=%b vld=%b data=%h err=%0d fail=%b s=%0d/%0d/%0d want all 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.out_data, bus.out_err_cnt,
                     bus.out_fail, bus.syn_s1, bus.syn_s2, bus.syn_s3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_word(15'h0010, od, oe, of, lat);
        checks++;
        if (od !== 15'h0 || oe !== 2'd1 || of !== 1'b0 || lat != FULL_LAT) begin
            errors++;
            $display("FAIL after_reset got data=%h err=%0d fail=%b lat=%0d want 0000 1 0 %0d",
                     od, oe, of, lat, FULL_LAT);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        force_zero    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 15'h0;
        bus.out_ready = 1'b1;
        #2;
        test_reset();
        test_zero_word();
        @(posedge clk); #1;
        test_single_error();
        @(posedge clk); #1;
        test_double_error();
        @(posedge clk); #1;
        test_uncorrectable();
        @(posedge clk); #1;
        test_backpressure();
        test_reset_in_chien();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
